logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 32-bit bitwise AND stage of the ALU.
- Performs one of eight bitwise operations on two WIDTH-bit operands per accepted transaction.
- Result flags: zero, all-ones, parity.
- Two register stages with valid/ready handshakes on both sides, so it drops into the ALU datapath between operand fetch and writeback with full backpressure support.

---
 rtl/logic_unit_pipe.sv | 110 +++++++++++
 tb/tb_logic_unit_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with result flags.
// Optional accumulator chaining is enabled by defining LU_ACCUM_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_r_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             ones_q;
    logic             parity_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] r_d;
    logic             s2_take;
    logic             s1_load;

`ifdef LU_ACCUM_EN
    logic [WIDTH-1:0] acc_q;
    assign b_eff = chain ? acc_q : b;
`else
    logic unused_chain;
    assign unused_chain = chain;
    assign b_eff        = b;
`endif

    always_comb begin
        r_d = '0;
        case (op)
            3'd0:    r_d = a & b_eff;
            3'd1:    r_d = a | b_eff;
            3'd2:    r_d = a ^ b_eff;
            3'd3:    r_d = ~(a & b_eff);
            3'd4:    r_d = ~(a | b_eff);
            3'd5:    r_d = ~(a ^ b_eff);
            3'd6:    r_d = a & ~b_eff;
            default: r_d = a;
        endcase
    end

    // in_ready looks through to out_ready so a full pipe still streams at one per cycle
    assign s2_take  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_take;
    assign s1_load  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_r_q     <= r_d;
        end else if (s2_take) begin
            s1_valid_q <= 1'b0;
        end
    end

`ifdef LU_ACCUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (s1_load) begin
            acc_q <= r_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            zero_q     <= 1'b0;
            ones_q     <= 1'b0;
            parity_q   <= 1'b0;
        end else if (s2_take) begin
            s2_valid_q <= 1'b1;
            y_q        <= s1_r_q;
            zero_q     <= ~|s1_r_q;
            ones_q     <= &s1_r_q;
            parity_q   <= ^s1_r_q;
        end else if (out_ready) begin
            // drained with nothing behind it: data and flags keep their last value
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed self-checking bench for logic_unit_pipe.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  op = '0;
    logic        chain = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic        zero;
    logic        ones;
    logic        parity;

    int checks = 0;
    int passes = 0;

    logic [31:0] sweep_exp [8] = '{32'h0000_00FF, 32'h00FF_FFFF, 32'h00FF_FF00, 32'hFFFF_FF00,
                                   32'hFF00_0000, 32'hFF00_00FF, 32'h0000_FF00, 32'h0000_FFFF};

    logic_unit_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .chain     (chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ones      (ones),
        .parity    (parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic c);
        in_valid = v;
        op       = o;
        a        = va;
        b        = vb;
        chain    = c;
    endtask

    initial begin
        #2;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_y", y, 32'd0);
        chk("reset_flags", {29'b0, zero, ones, parity}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        step();
        rst = 1'b0;
        step();

        // basic AND with two-edge latency
        drive(1'b1, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("and_not_yet_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("and_valid", {31'b0, out_valid}, 32'd1);
        chk("and_y", y, 32'hF000_F000);
        chk("and_flags", {29'b0, zero, ones, parity}, 32'd0);
        step();
        chk("and_drained", {31'b0, out_valid}, 32'd0);
        chk("and_y_held", y, 32'hF000_F000);

        // op sweep, one result per cycle
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drive(1'b1, 3'(k), 32'h0000_FFFF, 32'h00FF_00FF, 1'b0);
            else       drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
            step();
            if (k >= 1) begin
                chk($sformatf("sweep_valid_%0d", k - 1), {31'b0, out_valid}, 32'd1);
                chk($sformatf("sweep_y_%0d", k - 1), y, sweep_exp[k - 1]);
            end
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        step();

        // flags: all ones then zero
        drive(1'b1, 3'd4, 32'h0, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'd0, 32'h1, 32'h0, 1'b0);
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("nor_y", y, 32'hFFFF_FFFF);
        chk("nor_flags_z_o_p", {29'b0, zero, ones, parity}, 32'b010);
        step();
        chk("and0_y", y, 32'h0);
        chk("and0_flags_z_o_p", {29'b0, zero, ones, parity}, 32'b100);
        step();

        // backpressure: two accepts then in_ready drops, y held
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 32'h1234_5678, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'd7, 32'hCAFE_BABE, 32'h5555_5555, 1'b0);
        step();
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_y_first", y, 32'h1234_5678);
        step();
        step();
        chk("bp_y_held", y, 32'h1234_5678);
        chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
        chk("bp_in_ready_still_low", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", {31'b0, in_ready}, 32'd1);
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("bp_y_second", y, 32'hCAFE_BABE);
        step();
        chk("bp_y_third", y, 32'h0F0F_0F0F);
        chk("bp_third_valid", {31'b0, out_valid}, 32'd1);
        step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // async reset with both stages full
        out_ready = 1'b0;
        drive(1'b1, 3'd7, 32'hAAAA_0001, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'd7, 32'hBBBB_0002, 32'h0, 1'b0);
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("rst_pre_full", {31'b0, out_valid}, 32'd1);
        chk("rst_pre_in_ready", {31'b0, in_ready}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_async_y", y, 32'h0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready_after", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_no_stale_%0d", k), {31'b0, out_valid}, 32'd0);
        end

`ifdef LU_ACCUM_EN
        drive(1'b1, 3'd1, 32'h1, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'd1, 32'h2, 32'h0, 1'b1);
        step();
        drive(1'b1, 3'd2, 32'h7, 32'h0, 1'b1);
        chk("acc_y0", y, 32'h1);
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("acc_y1", y, 32'h3);
        step();
        chk("acc_y2", y, 32'h4);
        chk("acc_valid", {31'b0, out_valid}, 32'd1);
        step();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
